// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared types for the RV32I core.
//   mem_size_t  : load/store access size as encoded by the decoder
//                 (BYTE=00, HALF_WORD=01, WORD=11; 10 is illegal).
//   lsu_state_t : load/store unit control states.
//   is_misaligned() : natural-alignment check for a given size and addr[1:0].
// -----------------------------------------------------------------------------
package risc_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE      = 2'b00,
    MEM_HALF_WORD = 2'b01,
    MEM_WORD      = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    return ((size == MEM_HALF_WORD) && addr_lo[0]) ||
           ((size == MEM_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   size_i, addr_lo_i, wdata_i -> be_o, wdata_o  (store byte enables and
//                                                  lane-replicated data)
//   size_i, unsigned_i, addr_lo_i, rdata_i -> rdata_o (aligned, extended load)
// addr_lo_i is expected to be aligned for the given size already.
// -----------------------------------------------------------------------------
module lsu_align
  import risc_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Replicating the store data across lanes lets the memory pick whichever
  // lane the byte enables select, without a barrel shifter.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_HALF_WORD: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      MEM_WORD: be_o = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'b00:   load_byte = rdata_i[7:0];
      2'b01:   load_byte = rdata_i[15:8];
      2'b10:   load_byte = rdata_i[23:16];
      default: load_byte = rdata_i[31:24];
    endcase
  end

  assign load_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // WORD ignores unsigned_i: there is nothing left to extend.
  always_comb begin
    rdata_o = rdata_i;
    case (size_i)
      MEM_BYTE:      rdata_o = {{24{~unsigned_i & load_byte[7]}}, load_byte};
      MEM_HALF_WORD: rdata_o = {{16{~unsigned_i & load_half[15]}}, load_half};
      default:       rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory stage of the RV32I core: one load/store in flight at a time over a
// single-outstanding valid/ready data bus.
//   req_*  : request from execute (req_ready high only in IDLE)
//   mem_*  : data-memory bus (mem_addr word aligned; be/wdata lane steered)
//   rsp_*  : response to writeback (extended load data, rd, fault)
// Faults: illegal size 2'b10, bus timeout after TIMEOUT_CYCLES cycles in
// REQ+WAIT (0 disables), and misalignment when LSU_MISALIGN_TRAP_EN is
// defined. Without that macro, misaligned addresses are forced aligned.
// Reset: rst, asynchronous, active high.
// -----------------------------------------------------------------------------
module load_store_unit
  import risc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [4:0]      rsp_rd,
  output logic            rsp_fault
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  lsu_state_t      state_q;
  logic            we_q, unsigned_q;
  mem_size_t       size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [4:0]      rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic            req_ready_q, mem_valid_q, rsp_valid_q, rsp_fault_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic [4:0]      rsp_rd_q;

  logic            req_fault_d;
  logic [XLEN-1:0] addr_d;
  logic            timeout_hit;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata, load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_fault_d = (req_size == 2'b10) || is_misaligned(req_size, req_addr[1:0]);
  assign addr_d      = req_addr;
`else
  assign req_fault_d = (req_size == 2'b10);
  always_comb begin
    addr_d = req_addr;
    if (req_size == MEM_HALF_WORD)  addr_d[0]   = 1'b0;
    else if (req_size == MEM_WORD)  addr_d[1:0] = 2'b00;
  end
`endif

  // The count is cleared on entering REQ, so cnt_q == TO_LAST marks the
  // final allowed REQ/WAIT cycle. Timeout wins over a same-cycle handshake.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= MEM_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values regardless of statement order.
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            unsigned_q  <= req_unsigned;
            size_q      <= mem_size_t'(req_size);
            addr_q      <= addr_d;
            wdata_q     <= req_wdata;
            rd_q        <= req_we ? 5'd0 : req_rd;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (req_fault_d) begin
              state_q     <= LSU_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_rd_q    <= req_we ? 5'd0 : req_rd;
            end else begin
              state_q     <= LSU_REQ;
              mem_valid_q <= 1'b1;
            end
          end
        end
        LSU_REQ, LSU_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            state_q     <= LSU_RESP;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= rd_q;
          end else if ((state_q == LSU_REQ) && mem_ready) begin
            mem_valid_q <= 1'b0;
            if (we_q) begin
              state_q     <= LSU_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b0;
              rsp_rdata_q <= '0;
              rsp_rd_q    <= 5'd0;
            end else begin
              state_q <= LSU_WAIT;
            end
          end else if ((state_q == LSU_WAIT) && mem_rvalid) begin
            state_q     <= LSU_RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= load_data;
            rsp_rd_q    <= rd_q;
          end
        end
        LSU_RESP: begin
          if (rsp_ready) begin
            state_q     <= LSU_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  // Bus fields are gated by mem_valid so the bus reads all-zero when idle.
  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_valid_q & we_q;
  assign mem_be    = mem_valid_q ? lane_be : 4'b0000;
  assign mem_addr  = mem_valid_q ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata = mem_valid_q ? lane_wdata : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit (TIMEOUT_CYCLES = 8). The bench
// plays both the data memory and writeback. Expectations for LW to 0x102
// follow LSU_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) cycle <= cycle + 1;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_fault(rsp_fault)
  );

  typedef struct {
    bit          mem;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    exp_t        e;
  } vec_t;

  typedef struct {
    bit          done;
    int          mem_cycles;
    int          mem_cyc;
    bit          mem_unstable;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rsp_cyc;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        fault;
    bit          rsp_unstable;
    bit          busy_ready;
    bit          idle_ok;
  } obs_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input bit mem, input logic [3:0] be, input logic [31:0] maddr,
                         input logic [31:0] mwdata, input logic [31:0] rrdata,
                         input logic [4:0] rrd, input logic fault);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rd = rd;
    v.e.mem = mem; v.e.be = be; v.e.addr = maddr; v.e.wdata = mwdata;
    v.e.rdata = rrdata; v.e.rd = rrd; v.e.fault = fault;
    vecs.push_back(v);
  endtask

  // Reference model: byte-count/shift arithmetic straight from the access rules.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic [4:0] rd);
    exp_t        e;
    bit          trap = 1'b0;
    bit          mis;
    int          nb, sh;
    logic [31:0] a, mask, v;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`endif
    e = '{default: 0};
    mis = (size == 2'd1 && addr[0]) || (size == 2'd3 && (addr % 4) != 0);
    if (size == 2'd2 || (trap && mis)) begin
      e.fault = 1'b1;
      e.rd    = we ? 5'd0 : rd;
      return e;
    end
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a  = addr - (addr % nb);
    sh = a % 4;
    e.mem  = 1'b1;
    e.addr = a - (a % 4);
    e.be   = 4'(((1 << nb) - 1) << sh);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
    if (!we) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
      v = (rdata >> (8 * sh)) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.rdata = v;
      e.rd    = rd;
    end
    return e;
  endfunction

  // One complete transaction; acts as bus and writeback, samples at negedges.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] bus_rdata,
                         input int ready_dly, input int rvalid_dly, input int rsp_dly,
                         output obs_t o);
    int c0, n;
    int rdy_cnt = 0, rv_cnt = 0, rsp_cnt = 0;
    bit hs_pend = 0, in_wait = 0, rsp_fire = 0;
    o = '{default: 0};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    c0 = cycle;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!o.done && n < 300) begin
      mem_rvalid = 1'b0;
      if (hs_pend) begin
        hs_pend = 0; mem_ready = 1'b0;
        if (!we) in_wait = 1;
      end
      if (rsp_fire) begin
        rsp_fire  = 0;
        rsp_ready = 1'b0;
        o.idle_ok = req_ready && !rsp_valid;
        o.done    = 1;
      end else begin
        if (req_ready) o.busy_ready = 1;
        if (mem_valid) begin
          if (o.mem_cycles == 0) begin
            o.mem_cyc = cycle - c0; o.we = mem_we; o.be = mem_be;
            o.addr = mem_addr; o.wdata = mem_wdata;
          end else if (mem_we !== o.we || mem_be !== o.be || mem_addr !== o.addr ||
                       mem_wdata !== o.wdata) begin
            o.mem_unstable = 1;
          end
          o.mem_cycles++;
          if (rdy_cnt >= ready_dly) begin mem_ready = 1'b1; hs_pend = 1; end
          else begin rdy_cnt++; mem_ready = 1'b0; end
        end else begin
          mem_ready = 1'b0;
        end
        if (in_wait) begin
          if (rv_cnt >= rvalid_dly) begin
            mem_rvalid = 1'b1; mem_rdata = bus_rdata; in_wait = 0;
          end else rv_cnt++;
        end
        if (rsp_valid) begin
          if (o.rsp_cyc == 0) begin
            o.rsp_cyc = cycle - c0; o.rdata = rsp_rdata; o.rd = rsp_rd; o.fault = rsp_fault;
          end else if (rsp_rdata !== o.rdata || rsp_rd !== o.rd || rsp_fault !== o.fault) begin
            o.rsp_unstable = 1;
          end
          if (rsp_cnt >= rsp_dly) begin rsp_ready = 1'b1; rsp_fire = 1; end
          else rsp_cnt++;
        end
      end
      if (!o.done) @(negedge clk);
      n++;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
    if (!o.done) check("txn_completed", 32'd0, 32'd1);
  endtask

  task automatic check_txn(input string tag, input obs_t o, input exp_t e, input logic we,
                           input int ready_dly, input int rvalid_dly);
    int exp_cyc;
    exp_cyc = e.fault ? 1 : (we ? ready_dly + 2 : ready_dly + rvalid_dly + 3);
    check({tag, ".mem_cycles"}, o.mem_cycles, e.mem ? ready_dly + 1 : 0);
    if (e.mem) begin
      check({tag, ".mem_cyc"}, o.mem_cyc, 1);
      check({tag, ".mem_be"}, {28'd0, o.be}, {28'd0, e.be});
      check({tag, ".mem_addr"}, o.addr, e.addr);
      check({tag, ".mem_we"}, {31'd0, o.we}, {31'd0, we});
      check({tag, ".mem_stable"}, {31'd0, o.mem_unstable}, 32'd0);
      if (we) check({tag, ".mem_wdata"}, o.wdata, e.wdata);
    end
    check({tag, ".rsp_cyc"}, o.rsp_cyc, exp_cyc);
    check({tag, ".rsp_rdata"}, o.rdata, e.rdata);
    check({tag, ".rsp_fault"}, {31'd0, o.fault}, {31'd0, e.fault});
    if (!e.fault) check({tag, ".rsp_rd"}, {27'd0, o.rd}, {27'd0, e.rd});
    check({tag, ".rsp_stable"}, {31'd0, o.rsp_unstable}, 32'd0);
    check({tag, ".req_ready_busy"}, {31'd0, o.busy_ready}, 32'd0);
    check({tag, ".back_idle"}, {31'd0, o.idle_ok}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, ".mem_be"}, {28'd0, mem_be}, 32'd0);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, ".rsp_rd"}, {27'd0, rsp_rd}, 32'd0);
    check({tag, ".rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
  endtask

  initial begin
    obs_t o;
    exp_t e;

    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // we size uns addr wdata bus_rdata rd | mem be maddr mwdata rdata rd fault
    add_vec(1, 2'b11, 0, 32'h104, 32'hDEADBEEF, 32'h0, 5'd7,
            1, 4'hF, 32'h104, 32'hDEADBEEF, 32'h0, 5'd0, 0);
    add_vec(1, 2'b00, 0, 32'h203, 32'h000000A5, 32'h0, 5'd1,
            1, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0, 5'd0, 0);
    add_vec(1, 2'b01, 0, 32'h202, 32'h12345678, 32'h0, 5'd2,
            1, 4'hC, 32'h200, 32'h56785678, 32'h0, 5'd0, 0);
    add_vec(0, 2'b00, 0, 32'h101, 32'h0, 32'h00008000, 5'd5,
            1, 4'h2, 32'h100, 32'h0, 32'hFFFFFF80, 5'd5, 0);
    add_vec(0, 2'b00, 1, 32'h101, 32'h0, 32'h00008000, 5'd5,
            1, 4'h2, 32'h100, 32'h0, 32'h00000080, 5'd5, 0);
    add_vec(0, 2'b01, 0, 32'h102, 32'h0, 32'h80010000, 5'd9,
            1, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 5'd9, 0);
    add_vec(0, 2'b01, 1, 32'h100, 32'h0, 32'h1234F00D, 5'd10,
            1, 4'h3, 32'h100, 32'h0, 32'h0000F00D, 5'd10, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    add_vec(0, 2'b11, 0, 32'h102, 32'h0, 32'hCAFEBABE, 5'd3,
            0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd3, 1);
`else
    add_vec(0, 2'b11, 0, 32'h102, 32'h0, 32'hCAFEBABE, 5'd3,
            1, 4'hF, 32'h100, 32'h0, 32'hCAFEBABE, 5'd3, 0);
`endif
    add_vec(0, 2'b10, 0, 32'h100, 32'h0, 32'h11111111, 5'd4,
            0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd4, 1);
    add_vec(0, 2'b11, 1, 32'h108, 32'h0, 32'h80000000, 5'd6,
            1, 4'hF, 32'h108, 32'h0, 32'h80000000, 5'd6, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].rd, vecs[i].rdata, 0, 0, 0, o);
      check_txn($sformatf("vec%0d", i), o, vecs[i].e, vecs[i].we, 0, 0);
    end

    // mem_ready held low for 5 cycles
    e = model(1, 2'b11, 0, 32'h300, 32'h01020304, 32'h0, 5'd0);
    run_txn(1, 2'b11, 0, 32'h300, 32'h01020304, 5'd0, 32'h0, 5, 0, 0, o);
    check_txn("mem_bp", o, e, 1'b1, 5, 0);

    // rsp_ready held low for 3 cycles
    e = model(0, 2'b01, 0, 32'h302, 32'h0, 32'hBEEF1234, 5'd12);
    run_txn(0, 2'b01, 0, 32'h302, 32'h0, 5'd12, 32'hBEEF1234, 0, 1, 3, o);
    check_txn("rsp_bp", o, e, 1'b0, 0, 1);

    // timeout while waiting for read data
    run_txn(0, 2'b11, 0, 32'h400, 32'h0, 5'd8, 32'h12345678, 0, 1000, 0, o);
    check("to_wait.mem_cycles", o.mem_cycles, 1);
    check("to_wait.rsp_cyc", o.rsp_cyc, TO + 1);
    check("to_wait.rsp_fault", {31'd0, o.fault}, 32'd1);
    check("to_wait.rsp_rdata", o.rdata, 32'd0);
    check("to_wait.back_idle", {31'd0, o.idle_ok}, 32'd1);

    // timeout while the bus never accepts
    run_txn(1, 2'b00, 0, 32'h401, 32'h5A, 5'd0, 32'h0, 1000, 0, 0, o);
    check("to_req.mem_cycles", o.mem_cycles, TO);
    check("to_req.rsp_cyc", o.rsp_cyc, TO + 1);
    check("to_req.rsp_fault", {31'd0, o.fault}, 32'd1);
    check("to_req.rsp_rdata", o.rdata, 32'd0);

    // reset asserted while in WAIT, then a stale mem_rvalid
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 32'h500; req_rd = 5'd15;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_wait.mem_valid", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFACEFACE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stale_rvalid.rsp_valid%0d", k), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("stale_rvalid.req_ready%0d", k), {31'd0, req_ready}, 32'd1);
      @(negedge clk);
    end
    e = model(0, 2'b11, 0, 32'h504, 32'h0, 32'h0BADF00D, 5'd17);
    run_txn(0, 2'b11, 0, 32'h504, 32'h0, 5'd17, 32'h0BADF00D, 0, 0, 0, o);
    check_txn("post_rst_lw", o, e, 1'b0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata, r_rdata;
      logic [4:0]  r_rd;
      int          sel, rdy, rvd, rsd;
      sel     = $urandom_range(0, 7);
      r_size  = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 7) ? 2'b11 : 2'b10;
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = $urandom & 32'h0000_0FFF;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_rd    = 5'($urandom_range(1, 31));
      rdy     = $urandom_range(0, 2);
      rvd     = $urandom_range(0, 2);
      rsd     = $urandom_range(0, 2);
      e = model(r_we, r_size, r_uns, r_addr, r_wdata, r_rdata, r_rd);
      run_txn(r_we, r_size, r_uns, r_addr, r_wdata, r_rd, r_rdata, rdy, rvd, rsd, o);
      check_txn($sformatf("rnd%0d", i), o, e, r_we, rdy, rvd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
